// File: rtl/char_stream_feeder.sv
// Byte FIFO in front of the block-keyword checker. Runs of non-alphabetic bytes collapse to one 0x20.
// Optional feature: define CASE_FOLD_EN to write upper-case letters as lower case.
module char_stream_feeder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic [15:0]   squash_cnt
);

  // valid/ready: a byte moves on a rising edge only when valid and ready are both
  // high and flush is low; valid never depends on ready on either side.

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          last_sep;

  logic          is_upper;
  logic          is_alpha;
  logic          accept;
  logic          push;
  logic          pop;
  logic          squash;
  logic [7:0]    wdata;

  always_comb begin
    is_upper = (in_data >= 8'h41) && (in_data <= 8'h5A);
    is_alpha = is_upper || ((in_data >= 8'h61) && (in_data <= 8'h7A));
  end

  assign in_ready  = (count != DEPTH[AW:0]);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

  assign accept = in_valid && in_ready && !flush;
  assign push   = accept && (is_alpha || !last_sep);
  assign squash = accept && !is_alpha && last_sep;
  assign pop    = out_valid && out_ready && !flush;

  always_comb begin
    wdata = 8'h20;
    if (is_alpha) begin
`ifdef CASE_FOLD_EN
      wdata = is_upper ? (in_data + 8'h20) : in_data;
`else
      wdata = in_data;
`endif
    end
  end

  // Storage needs no reset: out_data is masked to 0x00 whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_sep <= 1'b1;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_sep <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (accept) begin
        last_sep <= !is_alpha;
      end
    end
  end

  // Discard counter survives flush so the host can read it after a restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      squash_cnt <= '0;
    end else if (squash && (squash_cnt != 16'hFFFF)) begin
      squash_cnt <= squash_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_char_stream_feeder.sv
// Directed bench for char_stream_feeder: separator collapse, full/wrap, streaming, flush and async reset.
module tb_char_stream_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [3:0] count;
  logic [15:0] squash_cnt;

  int checks = 0;
  int errors = 0;

  char_stream_feeder #(.DEPTH(8), .AW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .count      (count),
    .squash_cnt (squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 ||
        count !== 4'd0 || squash_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b data=%h cnt=%0d sq=%0d want 1 0 00 0 0",
               in_ready, out_valid, out_data, count, squash_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_begin;
    logic [7:0] src [5];
    logic [7:0] exp [5];
    src = '{8'h42, 8'h45, 8'h47, 8'h49, 8'h4E};
`ifdef CASE_FOLD_EN
    exp = '{8'h62, 8'h65, 8'h67, 8'h69, 8'h6E};
`else
    exp = '{8'h42, 8'h45, 8'h47, 8'h49, 8'h4E};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = src[i];
      step();
      checks++;
      if (out_data !== exp[i] || count !== 4'd1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL begin_out[%0d] got data=%h cnt=%0d vld=%b want %h 1 1",
                 i, out_data, count, out_valid, exp[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || squash_cnt !== 16'd0) begin
      errors++;
      $display("FAIL begin_end got cnt=%0d vld=%b sq=%0d want 0 0 0", count, out_valid, squash_cnt);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_separators;
    logic [7:0] src [11];
    logic [7:0] exp [6];
    src = '{8'h20, 8'h20, 8'h62, 8'h65, 8'h20, 8'h0A, 8'h09, 8'h20, 8'h67, 8'h69, 8'h6E};
    exp = '{8'h62, 8'h65, 8'h20, 8'h67, 8'h69, 8'h6E};
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_data  = src[i];
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd6 || squash_cnt !== 16'd5) begin
      errors++;
      $display("FAIL sep_count got cnt=%0d sq=%0d want 6 5", count, squash_cnt);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_data !== exp[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL sep_drain[%0d] got %h vld=%b want %h", i, out_data, out_valid, exp[i]);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL sep_empty got cnt=%0d want 0", count);
    end
  endtask

  task automatic test_full;
    logic [7:0] exp [10];
    exp = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69, 8'h6A};
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = exp[i];
      step();
    end
    in_data = exp[8];
    checks++;
    if (count !== 4'd8 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state got cnt=%0d rdy=%b want 8 0", count, in_ready);
    end
    step();
    checks++;
    if (count !== 4'd8 || out_data !== 8'h61) begin
      errors++;
      $display("FAIL full_hold got cnt=%0d head=%h want 8 61", count, out_data);
    end
    // Pop alone at full, then refill; repeat for the 10th byte.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd7 || in_ready !== 1'b1 || out_data !== 8'h62) begin
      errors++;
      $display("FAIL full_pop got cnt=%0d rdy=%b head=%h want 7 1 62", count, in_ready, out_data);
    end
    step();
    in_data   = exp[9];
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd8) begin
      errors++;
      $display("FAIL full_refill got cnt=%0d want 8", count);
    end
    out_ready = 1'b1;
    for (int i = 2; i < 10; i++) begin
      checks++;
      if (out_data !== exp[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_order[%0d] got %h want %h", i, out_data, exp[i]);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_empty got cnt=%0d vld=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] src [10];
    src = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69, 8'h6A};
    do_flush();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = src[i];
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = src[i+4];
      checks++;
      if (out_data !== src[i]) begin
        errors++;
        $display("FAIL b2b_out[%0d] got %h want %h", i, out_data, src[i]);
      end
      step();
      checks++;
      if (count !== 4'd4) begin
        errors++;
        $display("FAIL b2b_count[%0d] got %0d want 4", i, count);
      end
    end
    in_valid = 1'b0;
    for (int i = 6; i < 10; i++) begin
      checks++;
      if (out_data !== src[i]) begin
        errors++;
        $display("FAIL b2b_tail[%0d] got %h want %h", i, out_data, src[i]);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush;
    do_flush();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h61 + 8'(i);
      step();
    end
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL flush_pre got cnt=%0d want 5", count);
    end
    flush     = 1'b1;
    in_data   = 8'h7A;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 8'h00 || squash_cnt !== 16'd5) begin
      errors++;
      $display("FAIL flush_clear got cnt=%0d vld=%b data=%h sq=%0d want 0 0 00 5",
               count, out_valid, out_data, squash_cnt);
    end
    in_data = 8'h2E;
    step();
    checks++;
    if (count !== 4'd0 || squash_cnt !== 16'd6) begin
      errors++;
      $display("FAIL flush_squash got cnt=%0d sq=%0d want 0 6", count, squash_cnt);
    end
    in_data = 8'h61;
    step();
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd1 || out_data !== 8'h61) begin
      errors++;
      $display("FAIL flush_next got cnt=%0d data=%h want 1 61", count, out_data);
    end
  endtask

  task automatic test_async_reset;
    do_flush();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h71 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || squash_cnt !== 16'd0 ||
        in_ready !== 1'b1 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got vld=%b cnt=%0d sq=%0d rdy=%b data=%h want 0 0 0 1 00",
               out_valid, count, squash_cnt, in_ready, out_data);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_begin();
    test_separators();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
